// File: rtl/dmem_map_pkg.sv
// rtl/dmem_map_pkg.sv - shared address map for the data-memory responder
package dmem_map_pkg;

  localparam int unsigned ADDR_W   = 9;
  localparam int unsigned DATA_W   = 16;
  localparam int unsigned IO_WORDS = 16;

  localparam logic [ADDR_W-1:0] IO_BASE_DEFAULT = 9'h1F0;

  // Word offsets of the I/O registers above IO_BASE
  typedef enum logic [3:0] {
    IO_LED     = 4'd0,
    IO_SW      = 4'd1,
    IO_CNT_LO  = 4'd2,
    IO_CNT_HI  = 4'd3,
    IO_SW_RISE = 4'd4
  } io_reg_e;

  // RAM fills every word below the I/O window
  function automatic int unsigned ram_depth(input logic [ADDR_W-1:0] io_base);
    return {23'd0, io_base};
  endfunction

  localparam int unsigned RAM_DEPTH_DEFAULT = ram_depth(IO_BASE_DEFAULT);

endpackage

// File: rtl/dmem_ram.sv
// rtl/dmem_ram.sv - single-port write-first word RAM with registered output
module dmem_ram
  import dmem_map_pkg::*;
#(
  parameter int unsigned DEPTH = RAM_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] rdata_q;

  // Write-first: a write returns its own data on the read port
  always_comb begin
    rdata_d = rdata_q;
    if (en) begin
      rdata_d = we ? wdata : mem[addr];
    end
  end

  // Array write and output register; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[addr] <= wdata;
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - CPU data-memory responder: word RAM plus memory-mapped I/O
module dmem_responder
  import dmem_map_pkg::*;
#(
  parameter logic [ADDR_W-1:0] IO_BASE = IO_BASE_DEFAULT,
  parameter int unsigned       SW_W    = 10,
  parameter int unsigned       LED_W   = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dmem_en,
  input  logic              dmem_we,
  input  logic [ADDR_W-1:0] dmem_addr,
  input  logic [DATA_W-1:0] dmem_din,
  output logic [DATA_W-1:0] dmem_dout,
  input  logic [SW_W-1:0]   sw_in,
  output logic [LED_W-1:0]  led_out
);

  logic              req_rd;
  logic              req_wr;
  logic              is_io;
  logic              io_hit;
  logic [ADDR_W-1:0] io_off_full;
  logic [3:0]        io_off;
  logic              ram_en;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] io_rd_val;
  logic [SW_W-1:0]   rise_new;
  logic [SW_W-1:0]   rise_w1c;

  logic [LED_W-1:0]  led_d,      led_q;
  logic [31:0]       cnt_d,      cnt_q;
  logic [15:0]       cnt_snap_d, cnt_snap_q;
  logic [SW_W-1:0]   sw_s1_d,    sw_s1_q;
  logic [SW_W-1:0]   sw_s2_d,    sw_s2_q;
  logic [SW_W-1:0]   sw_prev_d,  sw_prev_q;
  logic [SW_W-1:0]   rise_d,     rise_q;
  logic              sel_io_d,   sel_io_q;
  logic [DATA_W-1:0] io_rdata_d, io_rdata_q;

  // Address decode: the full address is compared so nothing above IO_BASE reaches RAM
  always_comb begin
    req_rd      = dmem_en & ~dmem_we;
    req_wr      = dmem_en & dmem_we;
    is_io       = (dmem_addr >= IO_BASE);
    io_off_full = dmem_addr - IO_BASE;
    io_off      = io_off_full[3:0];
    io_hit      = is_io && (io_off_full < ADDR_W'(IO_WORDS));
    ram_en      = dmem_en & ~is_io & ~rst;
  end

  dmem_ram #(
    .DEPTH (ram_depth(IO_BASE))
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (dmem_we),
    .addr  (dmem_addr),
    .wdata (dmem_din),
    .rdata (ram_rdata)
  );

  // I/O read value for the current address; unmapped offsets read 0
  always_comb begin
    io_rd_val = '0;
    if (io_hit) begin
      case (io_off)
        IO_LED:     io_rd_val[LED_W-1:0] = led_q;
        IO_SW:      io_rd_val[SW_W-1:0]  = sw_s2_q;
        IO_CNT_LO:  io_rd_val            = cnt_q[15:0];
        IO_CNT_HI:  io_rd_val            = cnt_snap_q;
        IO_SW_RISE: io_rd_val[SW_W-1:0]  = rise_q;
        default:    io_rd_val            = '0;
      endcase
    end
  end

  // Next state of the I/O registers, switch synchronizer and output select
  always_comb begin
    led_d      = led_q;
    cnt_snap_d = cnt_snap_q;
    cnt_d      = cnt_q + 32'd1;
    rise_w1c   = '0;

    if (req_wr && io_hit) begin
      case (io_off)
        IO_LED:     led_d    = dmem_din[LED_W-1:0];
        IO_CNT_LO:  cnt_d    = '0;
        IO_SW_RISE: rise_w1c = dmem_din[SW_W-1:0];
        default:    ;
      endcase
    end

    // Snapshot the upper half so a following CNT_HI read is coherent with CNT_LO
    if (req_rd && io_hit && (io_off == IO_CNT_LO)) begin
      cnt_snap_d = cnt_q[31:16];
    end

    sw_s1_d   = sw_in;
    sw_s2_d   = sw_s1_q;
    sw_prev_d = sw_s2_q;
    rise_new  = sw_s2_q & ~sw_prev_q;
    // A fresh rise overrides a simultaneous clear on the same bit
    rise_d    = (rise_q & ~rise_w1c) | rise_new;

    // Reads choose the source; writes park the current output in io_rdata so
    // dmem_dout holds even though the write-first RAM port changes underneath
    sel_io_d   = sel_io_q;
    io_rdata_d = io_rdata_q;
    if (req_rd) begin
      sel_io_d = is_io;
      if (is_io) begin
        io_rdata_d = io_rd_val;
      end
    end else if (req_wr) begin
      sel_io_d   = 1'b1;
      io_rdata_d = dmem_dout;
    end
  end

  // State registers with synchronous reset; selecting the zeroed I/O path gives dout=0
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      cnt_q      <= '0;
      cnt_snap_q <= '0;
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      sw_prev_q  <= '0;
      rise_q     <= '0;
      sel_io_q   <= 1'b1;
      io_rdata_q <= '0;
    end else begin
      led_q      <= led_d;
      cnt_q      <= cnt_d;
      cnt_snap_q <= cnt_snap_d;
      sw_s1_q    <= sw_s1_d;
      sw_s2_q    <= sw_s2_d;
      sw_prev_q  <= sw_prev_d;
      rise_q     <= rise_d;
      sel_io_q   <= sel_io_d;
      io_rdata_q <= io_rdata_d;
    end
  end

  assign dmem_dout = sel_io_q ? io_rdata_q : ram_rdata;
  assign led_out   = led_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        dmem_en;
  logic        dmem_we;
  logic [8:0]  dmem_addr;
  logic [15:0] dmem_din;
  logic [15:0] dmem_dout;
  logic [9:0]  sw_in;
  logic [9:0]  led_out;

  int errors;
  int checks;

  dmem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .dmem_en   (dmem_en),
    .dmem_we   (dmem_we),
    .dmem_addr (dmem_addr),
    .dmem_din  (dmem_din),
    .dmem_dout (dmem_dout),
    .sw_in     (sw_in),
    .led_out   (led_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    dmem_en = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_wr(input logic [8:0] a, input logic [15:0] d);
    dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = a; dmem_din = d;
    step();
    dmem_en = 1'b0; dmem_we = 1'b0;
  endtask

  task automatic do_rd(input logic [8:0] a);
    dmem_en = 1'b1; dmem_we = 1'b0; dmem_addr = a;
    step();
    dmem_en = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    rst = 1'b1; dmem_en = 1'b0; dmem_we = 1'b0; dmem_addr = '0; dmem_din = '0; sw_in = '0;
    step(); step(); step();
    check("rst_dout", 32'(dmem_dout), 32'h0);
    check("rst_led", 32'(led_out), 32'h0);
    rst = 1'b0;

    // Counter starts at 0 and a CNT_LO read sees the pre-increment value
    do_rd(9'h1F2);
    check("cnt_first", 32'(dmem_dout), 32'h0);
    do_rd(9'h1F2);
    check("cnt_second", 32'(dmem_dout), 32'h1);
    do_rd(9'h1F4);
    check("rise_rst", 32'(dmem_dout), 32'h0);

    // RAM write then read, hold on idle and during a write
    do_wr(9'h010, 16'hBEEF);
    do_rd(9'h010);
    check("ram_rd", 32'(dmem_dout), 32'hBEEF);
    idle(1);
    check("ram_idle_hold", 32'(dmem_dout), 32'hBEEF);
    do_wr(9'h011, 16'h1111);
    check("ram_wr_hold", 32'(dmem_dout), 32'hBEEF);
    do_rd(9'h011);
    check("ram_rd2", 32'(dmem_dout), 32'h1111);

    // LED register and unmapped I/O
    do_wr(9'h1F0, 16'h03FF);
    check("led_wr", 32'(led_out), 32'h3FF);
    check("io_wr_hold", 32'(dmem_dout), 32'h1111);
    do_rd(9'h1F0);
    check("led_rd", 32'(dmem_dout), 32'h03FF);
    do_wr(9'h1F5, 16'h1234);
    do_rd(9'h1F5);
    check("unmapped_rd", 32'(dmem_dout), 32'h0);

    // I/O writes never alias into RAM
    do_wr(9'h000, 16'hA5A5);
    for (int off = 0; off < 16; off++) do_wr(9'h1F0 + 9'(off), 16'h1234);
    check("led_trunc", 32'(led_out), 32'h234);
    do_rd(9'h000);
    check("ram0_intact", 32'(dmem_dout), 32'hA5A5);
    for (int off = 5; off < 16; off++) begin
      do_rd(9'h1F0 + 9'(off));
      check($sformatf("unmapped_%0d", off), 32'(dmem_dout), 32'h0);
    end

    // Counter: clear, then read when it holds 0x1_0005
    do_wr(9'h1F2, 16'h0000);
    idle(32'h1_0005);
    do_rd(9'h1F2);
    check("cnt_lo", 32'(dmem_dout), 32'h0005);
    do_rd(9'h1F3);
    check("cnt_hi_snap", 32'(dmem_dout), 32'h0001);

    // Counter wrap from 0xFFFFFFFF
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    do_rd(9'h1F2);
    check("cnt_max_lo", 32'(dmem_dout), 32'hFFFF);
    do_rd(9'h1F2);
    check("cnt_wrap_lo", 32'(dmem_dout), 32'h0);
    do_rd(9'h1F3);
    check("cnt_wrap_hi", 32'(dmem_dout), 32'h0);

    // Switch synchronizer and sticky rise flags
    sw_in[3] = 1'b1;
    do_rd(9'h1F1);
    check("sw_sync_early", 32'(dmem_dout), 32'h0);
    idle(1);
    do_rd(9'h1F1);
    check("sw_sync", 32'(dmem_dout), 32'h0008);
    do_rd(9'h1F4);
    check("rise_set", 32'(dmem_dout), 32'h0008);
    do_wr(9'h1F4, 16'h0008);
    do_rd(9'h1F4);
    check("rise_w1c", 32'(dmem_dout), 32'h0);

    // Rise arriving on the same edge as its W1C stays set
    sw_in[3] = 1'b0;
    idle(4);
    sw_in[3] = 1'b1;
    idle(2);
    do_wr(9'h1F4, 16'h0008);
    do_rd(9'h1F4);
    check("rise_set_wins", 32'(dmem_dout), 32'h0008);
    sw_in = '0;

    // Reset during a RAM write
    do_wr(9'h020, 16'h5555);
    rst = 1'b1; dmem_en = 1'b1; dmem_we = 1'b1; dmem_addr = 9'h020; dmem_din = 16'hDEAD;
    step();
    dmem_en = 1'b0; dmem_we = 1'b0;
    check("rst_mid_dout", 32'(dmem_dout), 32'h0);
    check("rst_mid_led", 32'(led_out), 32'h0);
    rst = 1'b0;
    do_rd(9'h1F2);
    check("rst_cnt", 32'(dmem_dout), 32'h0);
    do_rd(9'h1F4);
    check("rst_rise", 32'(dmem_dout), 32'h0);
    do_rd(9'h020);
    check("rst_no_write", 32'(dmem_dout), 32'h5555);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
